psk_mod_gen: RTL and testbench

//  Parametrised successor of the fixed OQPSK transmitter: run-time selectable BPSK/QPSK/OQPSK

---
 rtl/psk_mod_pkg.sv | 30 +++
 rtl/psk_sincos_rom.sv | 55 +++++
 rtl/psk_mod_gen.sv | 172 +++++++++++++++++
 tb/tb_psk_mod_gen.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/psk_mod_pkg.sv
// Shared types and helpers for the BPSK/QPSK/OQPSK modulator.
//   mode_e       : modulation selector values as seen on the Mode input
//   amp()        : peak level A = 2^(R-1)-1 for an R-bit signed sample
//   quarter_off(): table offset of a quarter carrier turn (sin = cos shifted back)
//   decode_mode(): maps the raw 2-bit Mode input, reserved code 3 behaves as QPSK
package psk_mod_pkg;

  typedef enum logic [1:0] {
    MOD_BPSK  = 2'd0,
    MOD_QPSK  = 2'd1,
    MOD_OQPSK = 2'd2
  } mode_e;

  function automatic int amp(input int r);
    return (1 << (r - 1)) - 1;
  endfunction

  function automatic int quarter_off(input int luta);
    return 1 << (luta - 2);
  endfunction

  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd0:    return MOD_BPSK;
      2'd2:    return MOD_OQPSK;
      default: return MOD_QPSK;
    endcase
  endfunction

endpackage

// File: rtl/psk_sincos_rom.sv
// Registered cos/sin carrier table, one cycle of latency (pipeline stage 1).
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, clears both outputs
//   en     : clock enable, outputs hold while low
//   addr   : carrier phase address (top bits of the NCO phase)
//   cos_p1 : round(A*cos(2*pi*addr/2^LUTA)), registered
//   sin_p1 : same table read a quarter turn earlier, registered
module psk_sincos_rom
  import psk_mod_pkg::*;
#(
  parameter int R    = 7,
  parameter int LUTA = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [LUTA-1:0]     addr,
  output logic signed [R-1:0] cos_p1,
  output logic signed [R-1:0] sin_p1
);

  localparam int N = 1 << LUTA;
  localparam int A = amp(R);
  localparam logic [LUTA-1:0] QOFF = LUTA'(quarter_off(LUTA));

  // Table contents are fixed at elaboration; rounding is to nearest, halves away from zero.
  function automatic logic signed [R-1:0] lut_val(input int k);
    real v;
    v = real'(A) * $cos(2.0 * 3.14159265358979323846 * real'(k) / real'(N));
    if (v >= 0.0) return R'($rtoi(v + 0.5));
    else          return R'(-$rtoi(0.5 - v));
  endfunction

  logic signed [R-1:0] tab [N];
  logic [LUTA-1:0]     sin_addr;

  for (genvar k = 0; k < N; k++) begin : g_tab
    assign tab[k] = lut_val(k);
  end

  // sin(x) = cos(x - quarter turn); the subtraction wraps modulo the table size
  assign sin_addr = addr - QOFF;

  // ---- stage 1: table read ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cos_p1 <= '0;
      sin_p1 <= '0;
    end else if (en) begin
      cos_p1 <= tab[addr];
      sin_p1 <= tab[sin_addr];
    end
  end

endmodule

// File: rtl/psk_mod_gen.sv
// Run-time selectable BPSK/QPSK/OQPSK modulator with NCO carrier.
//   C        : clock, rising edge
//   Reset    : asynchronous active-low reset
//   En       : global enable, 0 freezes every register
//   Mode     : 0 BPSK, 1 QPSK, 2 OQPSK, 3 as QPSK; taken at symbol start
//   Fcw      : NCO frequency word
//   DValid   : I/Q bit pair valid; DI/DQ : data bits (1 -> +A, 0 -> -A)
//   DReady   : accepting a bit pair this cycle (symbol start)
//   S        : I*cos + Q*sin, 2R-bit signed, 3 cycles after level/phase update
//   SValid   : sample belongs to a modulated (non-idle) symbol
//   SymStb   : first sample of a symbol
//   Underrun : first sample of a symbol that found no data
module psk_mod_gen
  import psk_mod_pkg::*;
#(
  parameter int R    = 7,
  parameter int SPS  = 16,
  parameter int NCOW = 16,
  parameter int LUTA = 6
) (
  input  logic                  C,
  input  logic                  Reset,
  input  logic                  En,
  input  logic [1:0]            Mode,
  input  logic [NCOW-1:0]       Fcw,
  input  logic                  DValid,
  input  logic                  DI,
  input  logic                  DQ,
  output logic                  DReady,
  output logic signed [2*R-1:0] S,
  output logic                  SValid,
  output logic                  SymStb,
  output logic                  Underrun
);

  localparam int A  = amp(R);
  localparam int CW = $clog2(SPS);
  localparam int PW = 2 * R - 1;
  localparam int SW = 2 * R;
  localparam logic signed [R-1:0] LEV_P = R'(A);
  localparam logic signed [R-1:0] LEV_N = R'(-A);

  function automatic logic signed [R-1:0] level(input logic b);
    return b ? LEV_P : LEV_N;
  endfunction

  // |pI|+|pQ| <= 2*A^2 < 2^(2R-1): plain sign-extended add cannot overflow
  function automatic logic signed [SW-1:0] widen_add(input logic signed [PW-1:0] a,
                                                     input logic signed [PW-1:0] b);
    return SW'(a) + SW'(b);
  endfunction

  logic [CW-1:0]       symcnt;
  logic                sym_start, sym_half, sym_last;
  mode_e               mode_in, mode_q;
  logic                qhold;
  logic [NCOW-1:0]     phase_p0;
  logic signed [R-1:0] ilev_p0, qlev_p0;
  logic                stb_p0, vld_p0, und_p0;

  logic signed [R-1:0] ilev_p1, qlev_p1, cos_p1, sin_p1;
  logic                stb_p1, vld_p1, und_p1;

  logic signed [PW-1:0] pi_p2, pq_p2;
  logic                 stb_p2, vld_p2, und_p2;

  assign sym_start = (symcnt == '0);
  assign sym_half  = (symcnt == CW'(SPS / 2));
  assign sym_last  = (symcnt == CW'(SPS - 1));
  assign mode_in   = decode_mode(Mode);
  assign DReady    = Reset & En & sym_start;

  // ---- stage 0: symbol counter, bit handshake, levels, NCO phase ----
  always_ff @(posedge C or negedge Reset) begin
    if (!Reset) begin
      symcnt   <= '0;
      mode_q   <= MOD_BPSK;
      qhold    <= 1'b0;
      phase_p0 <= '0;
      ilev_p0  <= '0;
      qlev_p0  <= '0;
      stb_p0   <= 1'b0;
      vld_p0   <= 1'b0;
      und_p0   <= 1'b0;
    end else if (En) begin
      symcnt   <= sym_last ? '0 : symcnt + CW'(1);
      phase_p0 <= phase_p0 + Fcw;
      stb_p0   <= sym_start;
      und_p0   <= sym_start & ~DValid;
      if (sym_start) begin
        mode_q <= mode_in;
        vld_p0 <= DValid;
        if (DValid) begin
          ilev_p0 <= level(DI);
          case (mode_in)
            MOD_BPSK:  qlev_p0 <= '0;
            MOD_OQPSK: qhold   <= DQ;   // Q goes out half a symbol later
            default:   qlev_p0 <= level(DQ);
          endcase
        end else begin
          ilev_p0 <= '0;
          qlev_p0 <= '0;
          qhold   <= 1'b0;
        end
      end else if (sym_half && mode_q == MOD_OQPSK) begin
        qlev_p0 <= vld_p0 ? level(qhold) : '0;
      end
    end
  end

  // ---- stage 1: carrier lookup, levels and tags alongside ----
  psk_sincos_rom #(
    .R    (R),
    .LUTA (LUTA)
  ) u_rom (
    .clk    (C),
    .rst_n  (Reset),
    .en     (En),
    .addr   (phase_p0[NCOW-1 -: LUTA]),
    .cos_p1 (cos_p1),
    .sin_p1 (sin_p1)
  );

  always_ff @(posedge C or negedge Reset) begin
    if (!Reset) begin
      ilev_p1 <= '0;
      qlev_p1 <= '0;
      stb_p1  <= 1'b0;
      vld_p1  <= 1'b0;
      und_p1  <= 1'b0;
    end else if (En) begin
      ilev_p1 <= ilev_p0;
      qlev_p1 <= qlev_p0;
      stb_p1  <= stb_p0;
      vld_p1  <= vld_p0;
      und_p1  <= und_p0;
    end
  end

  // ---- stage 2: products ----
  always_ff @(posedge C or negedge Reset) begin
    if (!Reset) begin
      pi_p2  <= '0;
      pq_p2  <= '0;
      stb_p2 <= 1'b0;
      vld_p2 <= 1'b0;
      und_p2 <= 1'b0;
    end else if (En) begin
      pi_p2  <= PW'(ilev_p1 * cos_p1);
      pq_p2  <= PW'(qlev_p1 * sin_p1);
      stb_p2 <= stb_p1;
      vld_p2 <= vld_p1;
      und_p2 <= und_p1;
    end
  end

  // ---- stage 3: sum to output ----
  always_ff @(posedge C or negedge Reset) begin
    if (!Reset) begin
      S        <= '0;
      SymStb   <= 1'b0;
      SValid   <= 1'b0;
      Underrun <= 1'b0;
    end else if (En) begin
      S        <= widen_add(pi_p2, pq_p2);
      SymStb   <= stb_p2;
      SValid   <= vld_p2;
      Underrun <= und_p2;
    end
  end

endmodule

// File: tb/tb_psk_mod_gen.sv
// Directed bench for psk_mod_gen: a per-symbol table of inputs and hand-computed
// I/Q levels; each output sample is checked against the level and carrier
// expected three enabled cycles earlier.
module tb_psk_mod_gen;

  localparam int R    = 7;
  localparam int SPS  = 16;
  localparam int NCOW = 16;
  localparam int LUTA = 6;
  localparam int A    = 63;
  localparam int NV   = 21;

  logic                  C = 1'b0;
  logic                  Reset, En, DValid, DI, DQ;
  logic [1:0]            Mode;
  logic [NCOW-1:0]       Fcw;
  logic                  DReady, SValid, SymStb, Underrun;
  logic signed [2*R-1:0] S;

  psk_mod_gen #(.R(R), .SPS(SPS), .NCOW(NCOW), .LUTA(LUTA)) dut (
    .C(C), .Reset(Reset), .En(En), .Mode(Mode), .Fcw(Fcw), .DValid(DValid),
    .DI(DI), .DQ(DQ), .DReady(DReady), .S(S), .SValid(SValid), .SymStb(SymStb),
    .Underrun(Underrun)
  );

  always #5 C = ~C;

  typedef struct {
    logic [1:0]  mode;
    logic        dv;
    logic        di;
    logic        dq;
    logic [15:0] fcw;
    int          gap_off;   // En held low for gap_len cycles before this offset
    int          gap_len;
    int          rst_at;    // nonzero: reset asserted at this offset, symbol aborted
    int          ei;        // expected I level
    int          eqa;       // expected Q level, first half of symbol
    int          eqb;       // expected Q level, second half of symbol
    logic        evld;
  } vec_t;

  vec_t tbl [NV];

  // Carrier values at multiples of 1/8 turn: round(63*cos(k*pi/4))
  int c8 [8] = '{63, 45, 0, -45, -63, -45, 0, 45};

  // Expected stage-0 content after each enabled edge (index = edge number)
  int          e_i   [0:1023];
  int          e_q   [0:1023];
  int          e_stb [0:1023];
  int          e_vld [0:1023];
  int          e_und [0:1023];
  logic [15:0] e_ph  [0:1023];

  int          n;
  logic [15:0] ph;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t, edge %0d)", name, act, exp, $time, n);
    end
  endtask

  task automatic push(input int i, input int q, input int stb, input int vld,
                      input int und, input logic [15:0] fcw);
    ph = ph + fcw;
    e_i[n+1]   = i;
    e_q[n+1]   = q;
    e_stb[n+1] = stb;
    e_vld[n+1] = vld;
    e_und[n+1] = und;
    e_ph[n+1]  = ph;
  endtask

  task automatic check_out();
    int k, ei, eq, es, ev, eu;
    logic [15:0] p;
    logic [2:0]  ci, si;
    k = n - 3;
    if (k < 1) begin
      ei = 0; eq = 0; es = 0; ev = 0; eu = 0; p = '0;
    end else begin
      ei = e_i[k]; eq = e_q[k]; es = e_stb[k]; ev = e_vld[k]; eu = e_und[k]; p = e_ph[k];
    end
    ci = p[15:13];
    si = ci - 3'd2;
    chk("S", int'(S), ei * c8[ci] + eq * c8[si]);
    chk("SValid", int'(SValid), ev);
    chk("SymStb", int'(SymStb), es);
    chk("Underrun", int'(Underrun), eu);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_S"}, int'(S), 0);
    chk({tag, "_SValid"}, int'(SValid), 0);
    chk({tag, "_SymStb"}, int'(SymStb), 0);
    chk({tag, "_Underrun"}, int'(Underrun), 0);
    chk({tag, "_DReady"}, int'(DReady), 0);
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    repeat (2) @(negedge C);
    check_idle_outputs("rst_hold");
    Reset = 1'b1;
    En    = 1'b1;
    #1;
    chk("DReady_after_release", int'(DReady), 1);
    n  = 0;
    ph = '0;
  endtask

  initial begin
    //             mode  dv    di    dq    fcw       gof glen rst  ei  eqa  eqb  vld
    tbl[0]  = '{2'd1, 1'b1, 1'b1, 1'b0, 16'h4000, 0, 0, 0,  A, -A, -A, 1'b1};
    tbl[1]  = '{2'd1, 1'b1, 1'b1, 1'b0, 16'h4000, 0, 0, 0,  A, -A, -A, 1'b1};
    tbl[2]  = '{2'd1, 1'b1, 1'b0, 1'b1, 16'h4000, 0, 0, 0, -A,  A,  A, 1'b1};
    tbl[3]  = '{2'd0, 1'b1, 1'b1, 1'b1, 16'h4000, 0, 0, 0,  A,  0,  0, 1'b1};
    tbl[4]  = '{2'd0, 1'b1, 1'b0, 1'b0, 16'h4000, 0, 0, 0, -A,  0,  0, 1'b1};
    tbl[5]  = '{2'd0, 1'b1, 1'b1, 1'b1, 16'h4000, 0, 0, 0,  A,  0,  0, 1'b1};
    tbl[6]  = '{2'd2, 1'b1, 1'b1, 1'b1, 16'h4000, 0, 0, 0,  A,  0,  A, 1'b1};
    tbl[7]  = '{2'd2, 1'b1, 1'b0, 1'b0, 16'h4000, 0, 0, 0, -A,  A, -A, 1'b1};
    tbl[8]  = '{2'd2, 1'b1, 1'b1, 1'b1, 16'h4000, 0, 0, 0,  A, -A,  A, 1'b1};
    tbl[9]  = '{2'd2, 1'b0, 1'b1, 1'b1, 16'h4000, 0, 0, 0,  0,  0,  0, 1'b0};
    tbl[10] = '{2'd2, 1'b1, 1'b0, 1'b0, 16'h4000, 0, 0, 0, -A,  0, -A, 1'b1};
    tbl[11] = '{2'd3, 1'b1, 1'b1, 1'b1, 16'h4000, 0, 0, 0,  A,  A,  A, 1'b1};
    tbl[12] = '{2'd1, 1'b0, 1'b0, 1'b0, 16'h4000, 0, 0, 0,  0,  0,  0, 1'b0};
    tbl[13] = '{2'd1, 1'b1, 1'b1, 1'b1, 16'h4000, 0, 0, 0,  A,  A,  A, 1'b1};
    tbl[14] = '{2'd1, 1'b1, 1'b0, 1'b1, 16'h4000, 5, 5, 0, -A,  A,  A, 1'b1};
    tbl[15] = '{2'd0, 1'b1, 1'b1, 1'b1, 16'h2000, 0, 0, 0,  A,  0,  0, 1'b1};
    tbl[16] = '{2'd1, 1'b1, 1'b1, 1'b1, 16'h2000, 0, 0, 0,  A,  A,  A, 1'b1};
    tbl[17] = '{2'd1, 1'b1, 1'b0, 1'b1, 16'h0000, 0, 3, 0, -A,  A,  A, 1'b1};
    tbl[18] = '{2'd2, 1'b1, 1'b1, 1'b1, 16'h4000, 0, 0, 6,  A,  A,  A, 1'b1};
    tbl[19] = '{2'd2, 1'b1, 1'b1, 1'b0, 16'h4000, 0, 0, 0,  A,  0, -A, 1'b1};
    tbl[20] = '{2'd1, 1'b1, 1'b1, 1'b0, 16'h4000, 0, 0, 0,  A, -A, -A, 1'b1};

    Reset  = 1'b0;
    En     = 1'b1;
    Mode   = 2'd0;
    Fcw    = '0;
    DValid = 1'b0;
    DI     = 1'b0;
    DQ     = 1'b0;
    n      = 0;
    ph     = '0;

    repeat (3) @(negedge C);
    check_idle_outputs("reset");
    Reset = 1'b1;

    for (int k = 0; k < NV; k++) begin
      for (int o = 0; o < SPS; o++) begin
        if (tbl[k].gap_len > 0 && o == tbl[k].gap_off) begin
          for (int g = 0; g < tbl[k].gap_len; g++) begin
            En     = 1'b0;
            Fcw    = 16'($urandom);
            Mode   = 2'($urandom);
            DValid = 1'($urandom);
            DI     = 1'($urandom);
            DQ     = 1'($urandom);
            #1;
            chk("DReady_gap", int'(DReady), 0);
            @(posedge C);
            @(negedge C);
            check_out();
          end
        end
        if (tbl[k].rst_at > 0 && o == tbl[k].rst_at) begin
          do_reset();
          break;
        end
        En  = 1'b1;
        Fcw = tbl[k].fcw;
        if (o == 0) begin
          Mode   = tbl[k].mode;
          DValid = tbl[k].dv;
          DI     = tbl[k].di;
          DQ     = tbl[k].dq;
        end else begin
          Mode   = 2'($urandom);
          DValid = 1'($urandom);
          DI     = 1'($urandom);
          DQ     = 1'($urandom);
        end
        #1;
        chk("DReady", int'(DReady), (o == 0) ? 1 : 0);
        push(tbl[k].ei, (o < SPS / 2) ? tbl[k].eqa : tbl[k].eqb, (o == 0) ? 1 : 0,
             int'(tbl[k].evld), (o == 0 && !tbl[k].evld) ? 1 : 0, tbl[k].fcw);
        @(posedge C);
        n++;
        @(negedge C);
        check_out();
      end
    end

    // drain the pipeline so the last symbol's samples are compared too
    En     = 1'b1;
    DValid = 1'b1;
    DI     = 1'b1;
    DQ     = 1'b1;
    Mode   = 2'd1;
    Fcw    = 16'h4000;
    for (int d = 0; d < 3; d++) begin
      push(A, A, (d == 0) ? 1 : 0, 1, 0, 16'h4000);
      @(posedge C);
      n++;
      @(negedge C);
      check_out();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
